// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - control and display signal bundle for seg7_scan_driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic                      lz_suppress;
    logic [7:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      load_pending;
    logic                      frame_done;

    modport master (
        output enable, load, digits, dp, blank_mask, blink_mask, lz_suppress,
        input  seg, an, load_pending, frame_done
    );

    modport slave (
        input  enable, load, digits, dp, blank_mask, blink_mask, lz_suppress,
        output seg, an, load_pending, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scanner with frame-synchronous double buffering
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 25000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    frame_done_q, frame_done_d;
    logic                    load_pending_q, load_pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic       tick;
    logic       frame_wrap;
    logic [3:0] nibble;
    logic       upper_zero;
    logic       blank;

    // Segment patterns g..a, active low; bit 7 (dp) is merged separately
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        presc_d         = presc_q;
        idx_d           = idx_q;
        blink_cnt_d     = blink_cnt_q;
        blink_phase_d   = blink_phase_q;
        load_pending_d  = load_pending_q;
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        disp_digits_d   = disp_digits_q;
        disp_dp_d       = disp_dp_q;

        tick         = (presc_q == PRE_MAX);
        frame_wrap   = tick && (idx_q == IDX_MAX);
        frame_done_d = frame_wrap;

        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        if (bus.load) begin
            shadow_digits_d = bus.digits;
            shadow_dp_d     = bus.dp;
        end

        // A load coinciding with the commit stays pending for the following frame
        if (frame_wrap && load_pending_q) begin
            disp_digits_d  = shadow_digits_q;
            disp_dp_d      = shadow_dp_q;
            load_pending_d = bus.load;
        end else if (bus.load) begin
            load_pending_d = 1'b1;
        end

        if (frame_wrap) begin
            if (blink_cnt_q == BLK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        nibble     = disp_digits_q[{idx_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && disp_digits_q[j*4 +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        blank = bus.blank_mask[idx_q]
              | (bus.lz_suppress && (idx_q != '0) && upper_zero)
              | (blink_phase_q && bus.blink_mask[idx_q]);

        if (!bus.enable) begin
            an_d  = '1;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = blank ? 8'hFF : {~disp_dp_q[idx_q], decode(nibble)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q         <= '0;
            idx_q           <= '0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b0;
            frame_done_q    <= 1'b0;
            load_pending_q  <= 1'b0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            disp_digits_q   <= '0;
            disp_dp_q       <= '0;
            seg_q           <= 8'hFF;
            an_q            <= '1;
        end else begin
            presc_q         <= presc_d;
            idx_q           <= idx_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            frame_done_q    <= frame_done_d;
            load_pending_q  <= load_pending_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            disp_digits_q   <= disp_digits_d;
            disp_dp_q       <= disp_dp_d;
            seg_q           <= seg_d;
            an_q            <= an_d;
        end
    end

    assign bus.seg          = seg_q;
    assign bus.an           = an_q;
    assign bus.load_pending = load_pending_q;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (4 digits, div 4, blink 2)
module tb_seg7_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   frame_cnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt <= 0;
        else if (bus.frame_done) frame_cnt <= frame_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [3:0] v, input logic d, input logic blank);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        if (blank) return 8'hFF;
        return {~d, tbl[v][6:0]};
    endfunction

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_done(output int cnt);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            cnt++;
            if (bus.frame_done) break;
        end
        check_eq("frame_done_seen", bus.frame_done, 1);
    endtask

    task automatic push_frame(input string tag, input logic [15:0] dg, input logic [3:0] dpv,
                              input logic [3:0] blank);
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            e.tag = $sformatf("%s_d%0d", tag, i);
            e.an  = ~(4'b0001 << i);
            e.seg = ref_seg(dg[i*4 +: 4], dpv[i], blank[i]);
            sb.push_back(e);
        end
    endtask

    // Called at the negedge where frame_done is high; each digit is sampled on
    // every cycle it is held, ending one cycle before the next frame_done.
    task automatic capture_frame();
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            e = sb.pop_front();
            for (int c = 0; c < ((i == ND - 1) ? 3 : 4); c++) begin
                wait_negs(1);
                check_eq({e.tag, "_an"}, {28'h0, bus.an}, {28'h0, e.an});
                check_eq({e.tag, "_seg"}, {24'h0, bus.seg}, {24'h0, e.seg});
            end
        end
    endtask

    task automatic load_pulse(input logic [15:0] dg, input logic [3:0] dpv);
        bus.digits = dg;
        bus.dp     = dpv;
        bus.load   = 1'b1;
        wait_negs(1);
        bus.load   = 1'b0;
    endtask

    initial begin
        int cnt;
        int ph;
        bus.enable      = 1'b1;
        bus.load        = 1'b0;
        bus.digits      = '0;
        bus.dp          = '0;
        bus.blank_mask  = '0;
        bus.blink_mask  = '0;
        bus.lz_suppress = 1'b0;

        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_an", {28'h0, bus.an}, 32'hF);
        check_eq("rst_seg", {24'h0, bus.seg}, 32'hFF);
        check_eq("rst_pending", bus.load_pending, 0);
        check_eq("rst_frame_done", bus.frame_done, 0);
        wait_negs(2);
        rst_n = 1'b1;

        // Idle scan after reset
        wait_frame_done(cnt);
        check_eq("first_frame_latency", cnt, 16);
        push_frame("idle", 16'h0000, 4'b0000, 4'b0000);
        capture_frame();
        wait_frame_done(cnt);
        check_eq("frame_gap_a", cnt, 1);
        wait_negs(1);
        check_eq("frame_done_width", bus.frame_done, 0);
        wait_frame_done(cnt);
        check_eq("frame_period", cnt, 15);

        // Mid-frame load commits at the next boundary
        wait_negs(5);
        load_pulse(16'h12AF, 4'b0010);
        check_eq("pending_set", bus.load_pending, 1);
        wait_frame_done(cnt);
        check_eq("pending_clr", bus.load_pending, 0);
        push_frame("hex", 16'h12AF, 4'b0010, 4'b0000);
        capture_frame();

        // Leading-zero suppression
        bus.lz_suppress = 1'b1;
        wait_frame_done(cnt);
        wait_negs(2);
        load_pulse(16'h0050, 4'b0000);
        wait_frame_done(cnt);
        push_frame("lz50", 16'h0050, 4'b0000, 4'b1100);
        capture_frame();
        wait_frame_done(cnt);
        wait_negs(2);
        load_pulse(16'h0000, 4'b0000);
        wait_frame_done(cnt);
        push_frame("lz00", 16'h0000, 4'b0000, 4'b1110);
        capture_frame();

        // Blink on digit 0, phase derived from boundaries since reset
        bus.lz_suppress = 1'b0;
        bus.blink_mask  = 4'b0001;
        for (int f = 0; f < 4; f++) begin
            wait_frame_done(cnt);
            #1;
            ph = (frame_cnt / BF) % 2;
            push_frame($sformatf("blink%0d", f), 16'h0000, 4'b0000, {3'b000, ph[0]});
            capture_frame();
        end
        bus.blink_mask = 4'b0000;

        // Load exactly on the boundary tick while a load is already pending
        wait_frame_done(cnt);
        wait_negs(3);
        load_pulse(16'h3333, 4'b0000);
        wait_negs(11);
        load_pulse(16'h4444, 4'b1000);
        check_eq("bnd_frame_done", bus.frame_done, 1);
        check_eq("bnd_pending_kept", bus.load_pending, 1);
        push_frame("bndA", 16'h3333, 4'b0000, 4'b0000);
        capture_frame();
        wait_frame_done(cnt);
        check_eq("bnd_pending_clr", bus.load_pending, 0);
        push_frame("bndB", 16'h4444, 4'b1000, 4'b0000);
        capture_frame();

        // Enable low darkens the display but counters keep running
        wait_frame_done(cnt);
        wait_negs(2);
        bus.enable = 1'b0;
        wait_negs(1);
        check_eq("dis_an", {28'h0, bus.an}, 32'hF);
        check_eq("dis_seg", {24'h0, bus.seg}, 32'hFF);
        wait_frame_done(cnt);
        bus.enable = 1'b1;
        wait_negs(1);
        check_eq("en_an", {28'h0, bus.an}, 32'hE);
        check_eq("en_seg", {24'h0, bus.seg}, 32'h99);

        // Reset mid-frame with a pending load
        wait_negs(2);
        load_pulse(16'h5555, 4'b1111);
        check_eq("rst2_pending_pre", bus.load_pending, 1);
        wait_negs(3);
        rst_n = 1'b0;
        #1;
        check_eq("rst2_an", {28'h0, bus.an}, 32'hF);
        check_eq("rst2_seg", {24'h0, bus.seg}, 32'hFF);
        check_eq("rst2_pending", bus.load_pending, 0);
        check_eq("rst2_frame_done", bus.frame_done, 0);
        wait_negs(2);
        rst_n = 1'b1;
        wait_negs(1);
        check_eq("rst2_first_an", {28'h0, bus.an}, 32'hE);
        check_eq("rst2_first_seg", {24'h0, bus.seg}, 32'hC0);
        check_eq("rst2_pending_post", bus.load_pending, 0);
        wait_frame_done(cnt);
        check_eq("rst2_pending_frame", bus.load_pending, 0);
        push_frame("post_rst", 16'h0000, 4'b0000, 4'b0000);
        capture_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of scanned digits (range 2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 25000, clk cycles each digit is held (range 2 or more).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, scan frames per blink half-period (range 1 or more).
REQ-004 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  input  1  1 = display driven, 0 = all digits dark.
REQ-007 SHALL have port load  input  1  capture digits/dp into shadow buffer.
REQ-008 SHALL have port digits  input  4*NUM_DIGITS  hex nibbles, digit 0 at bits [3:0].
REQ-009 SHALL have port dp  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-010 SHALL have port blank_mask  input  NUM_DIGITS  1 = digit forced dark.
REQ-011 SHALL have port blink_mask  input  NUM_DIGITS  1 = digit blinks.
REQ-012 SHALL have port lz_suppress  input  1  1 = blank leading zeros.
REQ-013 SHALL have port seg  output  8  active-low segments, bit7 = dp, bits6:0 = g..a.
REQ-014 SHALL have port an  output  NUM_DIGITS  active-low digit enables, one-hot-low.
REQ-015 SHALL have port load_pending  output  1  shadow holds data not yet committed.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-017 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick is asserted in the cycle where the count equals REFRESH_DIV-1.
REQ-018 Digit index SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0; that wrap tick is the frame boundary.
REQ-019 frame_done SHALL be 1 for exactly the cycle after the frame-boundary tick.
REQ-020 load=1 SHALL write digits/dp into the shadow buffer and set load_pending=1 on the next edge; a repeated load while pending SHALL overwrite the shadow buffer.
REQ-021 At the frame boundary with load_pending=1, the display buffer SHALL take the shadow contents, and load_pending SHALL take the value of load in that cycle, so a coincident load stays pending for the next frame.
REQ-022 The display buffer SHALL change only at frame boundaries, so no frame shows mixed old and new data.
REQ-023 The segment decode SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, with bit7 then forced to ~dp[i].
REQ-024 A blanked digit SHALL output seg=FF while its an bit remains asserted.
REQ-025 With lz_suppress=1, every digit i>0 for which digit i and all higher digits are 0 SHALL be blanked; digit 0 SHALL never be suppressed.
REQ-026 A blink phase bit SHALL toggle every BLINK_FRAMES frame boundaries; when it is 1, digits with blink_mask=1 SHALL be blanked.
REQ-027 The blank condition for a digit SHALL be the OR of blank_mask, leading-zero suppression and blink.
REQ-028 seg and an SHALL be registered with exactly 1 cycle of latency from the digit-index change.
REQ-029 With enable=0, an SHALL be all 1s and seg SHALL be FF on the next edge, while the counters, commit logic and blink logic keep running.

Reset
REQ-030 Asserting rst_n=0 SHALL clear immediately: an=all 1s, seg=FF, frame_done=0, load_pending=0, prescaler=0, index=0, blink phase=0, both buffers=0.
REQ-031 Reset asserted mid-frame or mid-pending SHALL discard the shadow data; scanning restarts at digit 0 after release.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-032 Reset then enable=1 with no load -> an walks 1110, 1101, 1011, 0111, each held 4 cycles; seg=C0 throughout; frame_done pulses every 16 cycles.
REQ-033 load with digits=12AF, dp=0010 mid-frame -> load_pending=1 until the boundary; the next frame shows digit0=8E, digit1=08 (dp lit), digit2=A4, digit3=F9.
REQ-034 digits=0050 with lz_suppress=1 -> digit3=FF, digit2=FF, digit1=92, digit0=C0; digits=0000 -> only digit0 shows C0.
REQ-035 blink_mask=0001 -> digit0 shows its value for 2 frames, then FF for 2 frames, repeating; the other digits are unaffected.
REQ-036 load asserted exactly on the boundary tick -> the previous shadow commits and load_pending stays 1; the new data commits one frame later.
REQ-037 rst_n pulsed low mid-frame with load_pending=1 -> outputs immediately an=1111, seg=FF; after release, digit 0 shows C0 and load_pending=0.
